// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
// Holds up to two fetched pc/instr pairs so the fetch stage sees a registered
// ready while decode applies backpressure. Occupancy is tracked by a
// three-state FSM (EMPTY/ONE/FULL). A separate saturating counter tracks stall
// cycles on the decode side.
module ifid_skid_reg #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [7:0]         stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               accept;
  logic               drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next occupancy; a flush empties the buffer regardless of handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !drain)      state_nxt = FULL;
        else if (!accept && drain) state_nxt = EMPTY;
        else                       state_nxt = ONE;
      end
      FULL:    if (drain) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Occupancy FSM with registered handshake outputs and the two data entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      // Data moves only when the buffer survives this cycle; flushed data is dropped.
      if (!flush) begin
        case (state)
          EMPTY: begin
            if (accept) begin
              out_pc    <= in_pc;
              out_instr <= in_instr;
            end
          end
          ONE: begin
            if (accept && drain) begin
              out_pc    <= in_pc;
              out_instr <= in_instr;
            end else if (accept) begin
              skid_pc    <= in_pc;
              skid_instr <= in_instr;
            end
          end
          FULL: begin
            if (drain) begin
              out_pc    <= skid_pc;
              out_instr <= skid_instr;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Count cycles where decode holds a valid entry but refuses it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 8'h00;
    end else if (out_valid && !out_ready) begin
      stall_cnt <= sat_inc8(stall_cnt);
    end
  end

endmodule

// File: doc/ifid_skid_reg.md
IFID_SKID_REG -- requirements
Module: ifid_skid_reg

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter width in bits.
REQ-002 SHALL have parameter INSTR_W, default 32, meaning instruction width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-005 SHALL have port flush  input  1  discards all buffered fetch entries (branch/jump redirect).
REQ-006 SHALL have port in_valid  input  1  fetch stage presents a valid pc/instr pair.
REQ-007 SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-008 SHALL have port in_pc  input  PC_W  PC of the fetched instruction.
REQ-009 SHALL have port in_instr  input  INSTR_W  fetched instruction word.
REQ-010 SHALL have port out_valid  output  1  decode-side entry valid.
REQ-011 SHALL have port out_ready  input  1  decode stage consumes the entry this cycle.
REQ-012 SHALL have port out_pc  output  PC_W  PC of the head entry.
REQ-013 SHALL have port out_instr  output  INSTR_W  instruction of the head entry.
REQ-014 SHALL have port stall_cnt  output  8  saturating count of backpressure cycles.

Function
REQ-015 SHALL define accept = in_valid & in_ready and drain = out_valid & out_ready, both sampled at posedge clk.
REQ-016 SHALL hold two entries: main (drives out_pc/out_instr) and skid; occupancy FSM states EMPTY, ONE, FULL.
REQ-017 SHALL drive out_valid = 1 in ONE and FULL, and 0 in EMPTY; out_valid SHALL be a registered output.
REQ-018 SHALL drive in_ready from a register whose next value is (next_state != FULL); in_ready is 0 only in FULL, or during/after reset until the first posedge.
REQ-019 EMPTY: accept -> ONE, main <= in; otherwise stay.
REQ-020 ONE: accept & !drain -> FULL, skid <= in; accept & drain -> ONE, main <= in; !accept & drain -> EMPTY; neither -> stay, main held.
REQ-021 FULL: drain -> ONE, main <= skid; otherwise stay; no accept is possible (in_ready = 0).
REQ-022 SHALL provide one-cycle latency: an entry accepted at edge N is visible on out_* with out_valid = 1 after edge N, when the block was EMPTY or draining in ONE.
REQ-023 SHALL preserve strict FIFO order; no entry is duplicated or lost absent flush/reset.
REQ-024 flush = 1 SHALL force next_state = EMPTY, overriding all transitions; an accept or drain handshake in the flush cycle completes, but accepted data is discarded.
REQ-025 SHALL keep out_pc/out_instr stable while out_valid = 1 and out_ready = 0.
REQ-026 stall_cnt SHALL increment by 1 on each posedge where out_valid = 1 and out_ready = 0, saturate at 8'hFF, and be unaffected by flush.
REQ-027 SHALL leave data registers unchanged on cycles with no load; their contents are don't-care while the entry is invalid.

Reset
REQ-028 reset low SHALL asynchronously force state EMPTY, out_valid 0, in_ready 0, out_pc 0, out_instr 0, skid data 0, and stall_cnt 0.
REQ-029 On the first posedge after reset rises, in_ready SHALL become 1; no accept is possible before that edge.
REQ-030 Reset asserted mid-operation, including in FULL, SHALL drop all entries with no partial transfer.

Verification
REQ-031 Streaming: out_ready = 1, pcs 0x0,0x4,0x8 on three consecutive cycles -> out_pc 0x0,0x4,0x8 on consecutive cycles, out_valid high continuously, in_ready stays 1.
REQ-032 Backpressure: out_ready = 0, send pcs 0x10, 0x14 -> FULL, in_ready = 0, out_pc holds 0x10, stall_cnt increments each cycle; raise out_ready -> 0x10 then 0x14, and in_ready returns to 1 one cycle after the first drain.
REQ-033 Flush in FULL with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and no old pc ever appears on out_pc.
REQ-034 Async reset: drive reset low between clock edges while in ONE -> out_valid and in_ready go 0 immediately; after release, in_ready = 1 at the first posedge.
REQ-035 Saturation: hold out_valid = 1, out_ready = 0 for 300 cycles -> stall_cnt = 8'hFF, no wrap.
